// File: rtl/swerv_types.sv
// Shared LSU types: stage packet and DMA size codes.
// Used by the LSU packet pipeline and its stages.
package swerv_types;

  typedef struct packed {
    logic valid;
    logic load;
    logic store;
    logic by;
    logic half;
    logic word;
    logic dma;
    logic unsign;
  } lsu_pkt_t;

  localparam logic [2:0] SZ_BYTE = 3'd0;
  localparam logic [2:0] SZ_HALF = 3'd1;
  localparam logic [2:0] SZ_WORD = 3'd2;

endpackage

// File: rtl/lsu_pipe_stage.sv
// One LSU pipe stage: packet plus address register.
// Hold keeps contents, kill drops non-DMA valids.
module lsu_pipe_stage
  import swerv_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        kill,
  input  lsu_pkt_t    pkt_in,
  input  logic [31:0] addr_in,
  output lsu_pkt_t    pkt,
  output logic [31:0] addr
);

  lsu_pkt_t    pkt_nxt;
  logic [31:0] addr_nxt;

  // Pick held or incoming contents, then apply flush kill
  always_comb begin
    pkt_nxt  = hold ? pkt  : pkt_in;
    addr_nxt = hold ? addr : addr_in;
    if (kill && !pkt_nxt.dma)
      pkt_nxt.valid = 1'b0;
  end

  // Stage register with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt  <= '0;
      addr <= '0;
    end else begin
      pkt  <= pkt_nxt;
      addr <= addr_nxt;
    end
  end

endmodule

// File: rtl/lsu_pkt_pipe.sv
// LSU packet pipeline dc1..dc5 with DMA injection,
// freeze and flush, plus dc2 region decode.
module lsu_pkt_pipe
  import swerv_types::*;
#(
  parameter logic [31:0] DCCM_BASE = 32'hF004_0000,
  parameter logic [31:0] DCCM_SIZE = 32'h0001_0000,
  parameter logic [31:0] PIC_BASE  = 32'hF00C_0000,
  parameter logic [31:0] PIC_SIZE  = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        rst,
  input  lsu_pkt_t    lsu_p,
  input  logic [31:0] lsu_addr_d,
  input  logic        dma_dccm_req,
  input  logic [31:0] dma_mem_addr,
  input  logic [2:0]  dma_mem_sz,
  input  logic        dma_mem_write,
  input  logic        lsu_freeze_dc3,
  input  logic        dec_tlu_flush_lower_wb,
  output logic        dma_dccm_ready,
  output logic        lsu_stall_d,
  output lsu_pkt_t    lsu_pkt_dc1,
  output lsu_pkt_t    lsu_pkt_dc2,
  output lsu_pkt_t    lsu_pkt_dc3,
  output lsu_pkt_t    lsu_pkt_dc4,
  output lsu_pkt_t    lsu_pkt_dc5,
  output logic [31:0] lsu_addr_dc1,
  output logic [31:0] lsu_addr_dc2,
  output logic [31:0] lsu_addr_dc3,
  output logic [31:0] lsu_addr_dc4,
  output logic [31:0] lsu_addr_dc5,
  output logic        addr_in_dccm_dc2,
  output logic        addr_in_pic_dc2,
  output logic        lsu_idle_any
);

  localparam int DW = $clog2(DCCM_SIZE);
  localparam int PW = $clog2(PIC_SIZE);

  logic        frz;
  logic        flush;
  lsu_pkt_t    dma_pkt;
  lsu_pkt_t    src_pkt;
  logic [31:0] src_addr;
  lsu_pkt_t    dc4_in;

  assign frz   = lsu_freeze_dc3;
  assign flush = dec_tlu_flush_lower_wb;

  assign dma_dccm_ready = dma_dccm_req & ~lsu_p.valid
                        & ~frz & ~flush;
  assign lsu_stall_d    = frz;

  // Build the DMA packet from the request attributes
  always_comb begin
    dma_pkt       = '0;
    dma_pkt.valid = 1'b1;
    dma_pkt.dma   = 1'b1;
    dma_pkt.store = dma_mem_write;
    dma_pkt.load  = ~dma_mem_write;
    dma_pkt.by    = (dma_mem_sz == SZ_BYTE);
    dma_pkt.half  = (dma_mem_sz == SZ_HALF);
    dma_pkt.word  = (dma_mem_sz >= SZ_WORD);
  end

  // Stage-1 source: decode first, DMA when decode is idle
  always_comb begin
    src_pkt  = '0;
    src_addr = lsu_addr_d;
    if (dma_dccm_ready) begin
      src_pkt  = dma_pkt;
      src_addr = dma_mem_addr;
    end else if (lsu_p.valid && !flush) begin
      src_pkt  = lsu_p;
    end
  end

  // Freeze drops a bubble into dc4 behind the held dc3
  assign dc4_in = frz ? '0 : lsu_pkt_dc3;

  lsu_pipe_stage u_dc1 (
    .clk(clk), .rst(rst),
    .hold(frz), .kill(flush),
    .pkt_in(src_pkt), .addr_in(src_addr),
    .pkt(lsu_pkt_dc1), .addr(lsu_addr_dc1)
  );

  lsu_pipe_stage u_dc2 (
    .clk(clk), .rst(rst),
    .hold(frz), .kill(flush),
    .pkt_in(lsu_pkt_dc1), .addr_in(lsu_addr_dc1),
    .pkt(lsu_pkt_dc2), .addr(lsu_addr_dc2)
  );

  lsu_pipe_stage u_dc3 (
    .clk(clk), .rst(rst),
    .hold(frz), .kill(flush),
    .pkt_in(lsu_pkt_dc2), .addr_in(lsu_addr_dc2),
    .pkt(lsu_pkt_dc3), .addr(lsu_addr_dc3)
  );

  lsu_pipe_stage u_dc4 (
    .clk(clk), .rst(rst),
    .hold(1'b0), .kill(flush),
    .pkt_in(dc4_in), .addr_in(lsu_addr_dc3),
    .pkt(lsu_pkt_dc4), .addr(lsu_addr_dc4)
  );

  lsu_pipe_stage u_dc5 (
    .clk(clk), .rst(rst),
    .hold(1'b0), .kill(1'b0),
    .pkt_in(lsu_pkt_dc4), .addr_in(lsu_addr_dc4),
    .pkt(lsu_pkt_dc5), .addr(lsu_addr_dc5)
  );

  assign addr_in_dccm_dc2 = lsu_pkt_dc2.valid
    & (lsu_addr_dc2[31:DW] == DCCM_BASE[31:DW]);
  assign addr_in_pic_dc2  = lsu_pkt_dc2.valid
    & (lsu_addr_dc2[31:PW] == PIC_BASE[31:PW]);

  assign lsu_idle_any = ~(lsu_pkt_dc1.valid | lsu_pkt_dc2.valid
                        | lsu_pkt_dc3.valid | lsu_pkt_dc4.valid
                        | lsu_pkt_dc5.valid);

  // Overlapping regions are a broken configuration
  a_no_overlap: assert property (@(posedge clk) disable iff (rst)
    !(addr_in_dccm_dc2 && addr_in_pic_dc2));

endmodule

// File: tb/tb_lsu_pkt_pipe.sv
// Self-checking bench for lsu_pkt_pipe: directed
// vectors, a stage-array model and literal checks.
module tb_lsu_pkt_pipe;
  import swerv_types::*;

  localparam logic [31:0] DB = 32'hF004_0000;
  localparam logic [31:0] DS = 32'h0001_0000;
  localparam logic [31:0] PB = 32'hF00C_0000;
  localparam logic [31:0] PS = 32'h0000_8000;

  logic        clk = 1'b0;
  logic        rst;
  lsu_pkt_t    lsu_p;
  logic [31:0] lsu_addr_d;
  logic        dma_req;
  logic [31:0] dma_addr;
  logic [2:0]  dma_sz;
  logic        dma_wr;
  logic        frz;
  logic        flush;
  logic        ready;
  logic        stall;
  lsu_pkt_t    dp [1:5];
  logic [31:0] da [1:5];
  logic        in_dccm;
  logic        in_pic;
  logic        idle;

  int checks = 0;
  int errors = 0;

  lsu_pkt_t    mp [0:5];
  logic [31:0] ma [0:5];

  lsu_pkt_pipe #(
    .DCCM_BASE(DB), .DCCM_SIZE(DS),
    .PIC_BASE(PB), .PIC_SIZE(PS)
  ) dut (
    .clk(clk), .rst(rst),
    .lsu_p(lsu_p), .lsu_addr_d(lsu_addr_d),
    .dma_dccm_req(dma_req), .dma_mem_addr(dma_addr),
    .dma_mem_sz(dma_sz), .dma_mem_write(dma_wr),
    .lsu_freeze_dc3(frz),
    .dec_tlu_flush_lower_wb(flush),
    .dma_dccm_ready(ready), .lsu_stall_d(stall),
    .lsu_pkt_dc1(dp[1]), .lsu_pkt_dc2(dp[2]),
    .lsu_pkt_dc3(dp[3]), .lsu_pkt_dc4(dp[4]),
    .lsu_pkt_dc5(dp[5]),
    .lsu_addr_dc1(da[1]), .lsu_addr_dc2(da[2]),
    .lsu_addr_dc3(da[3]), .lsu_addr_dc4(da[4]),
    .lsu_addr_dc5(da[5]),
    .addr_in_dccm_dc2(in_dccm), .addr_in_pic_dc2(in_pic),
    .lsu_idle_any(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic in_rgn(logic [31:0] a,
                                  logic [31:0] b,
                                  logic [31:0] s);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, b};
    return off < {1'b0, s};
  endfunction

  function automatic lsu_pkt_t mk(logic ld, logic st);
    lsu_pkt_t p;
    p = '0;
    p.valid = 1'b1;
    p.load  = ld;
    p.store = st;
    p.word  = 1'b1;
    return p;
  endfunction

  function automatic logic exp_ready();
    return dma_req && !lsu_p.valid && !frz && !flush;
  endfunction

  // Behavioural model: packets march one slot per edge,
  // freeze parks slots 1-3, flush clears decode valids.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= 5; k++) begin
        mp[k] = '0;
        ma[k] = '0;
      end
    end else begin
      lsu_pkt_t    np [0:5];
      logic [31:0] na [0:5];
      np[0] = '0;
      na[0] = '0;
      if (exp_ready()) begin
        np[0] = '0;
        np[0].valid = 1'b1;
        np[0].dma   = 1'b1;
        np[0].store = dma_wr;
        np[0].load  = !dma_wr;
        np[0].by    = dma_sz == 3'd0;
        np[0].half  = dma_sz == 3'd1;
        np[0].word  = dma_sz > 3'd1;
        na[0] = dma_addr;
      end else if (lsu_p.valid && !flush) begin
        np[0] = lsu_p;
        na[0] = lsu_addr_d;
      end
      np[5] = mp[4];
      na[5] = ma[4];
      np[4] = frz ? lsu_pkt_t'('0) : mp[3];
      na[4] = ma[3];
      for (int k = 3; k >= 1; k--) begin
        np[k] = frz ? mp[k] : (k == 1 ? np[0] : mp[k-1]);
        na[k] = frz ? ma[k] : (k == 1 ? na[0] : ma[k-1]);
      end
      for (int k = 1; k <= 4; k++)
        if (flush && !np[k].dma) np[k].valid = 1'b0;
      for (int k = 1; k <= 5; k++) begin
        mp[k] = np[k];
        ma[k] = na[k];
      end
    end
  end

  // Compare every DUT output against the model each cycle
  always @(negedge clk) begin
    logic any;
    any = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("dc%0d_valid", k), 64'(dp[k].valid),
          64'(mp[k].valid));
      any = any | mp[k].valid;
      if (mp[k].valid) begin
        chk($sformatf("dc%0d_pkt", k), 64'(dp[k]), 64'(mp[k]));
        chk($sformatf("dc%0d_addr", k), 64'(da[k]), 64'(ma[k]));
      end
    end
    chk("idle", 64'(idle), 64'(!any));
    chk("ready", 64'(ready), 64'(exp_ready()));
    chk("stall", 64'(stall), 64'(frz));
    chk("in_dccm", 64'(in_dccm),
        64'(mp[2].valid && in_rgn(ma[2], DB, DS)));
    chk("in_pic", 64'(in_pic),
        64'(mp[2].valid && in_rgn(ma[2], PB, PS)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    lsu_p      = '0;
    lsu_addr_d = '0;
    dma_req    = 1'b0;
    dma_addr   = '0;
    dma_sz     = '0;
    dma_wr     = 1'b0;
    frz        = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic send(lsu_pkt_t p, logic [31:0] a);
    lsu_p      = p;
    lsu_addr_d = a;
    tick();
  endtask

  task automatic drain();
    quiet();
    repeat (6) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    quiet();
    tick();
    tick();
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_dc1", 64'(dp[1]), 64'd0);
    chk("rst_addr5", 64'(da[5]), 64'd0);
    chk("rst_dccm", 64'(in_dccm), 64'd0);
    rst = 1'b0;
    tick();

    // Plain load through all five stages
    send(mk(1, 0), 32'hF004_0010);
    quiet();
    chk("t1_dc1", 64'(dp[1].valid), 64'd1);
    chk("t1_idle1", 64'(idle), 64'd0);
    tick();
    chk("t1_dccm", 64'(in_dccm), 64'd1);
    tick();
    tick();
    tick();
    chk("t1_dc5", 64'(dp[5].valid), 64'd1);
    chk("t1_idle5", 64'(idle), 64'd0);
    tick();
    chk("t1_idle6", 64'(idle), 64'd1);

    // DMA blocked by decode, accepted next cycle
    dma_req  = 1'b1;
    dma_addr = 32'hF00C_0004;
    dma_sz   = 3'd1;
    dma_wr   = 1'b1;
    lsu_p      = mk(0, 1);
    lsu_addr_d = 32'hF004_0020;
    #1;
    chk("t2_rdy0", 64'(ready), 64'd0);
    tick();
    lsu_p = '0;
    #1;
    chk("t2_rdy1", 64'(ready), 64'd1);
    tick();
    dma_req = 1'b0;
    chk("t2_dma", 64'(dp[1].dma), 64'd1);
    chk("t2_store", 64'(dp[1].store), 64'd1);
    chk("t2_half", 64'(dp[1].half), 64'd1);
    tick();
    chk("t2_pic", 64'(in_pic), 64'd1);
    drain();

    // Stream Z,A,B,C then freeze three cycles
    send(mk(1, 0), 32'h0000_1000);
    send(mk(1, 0), 32'h0000_100A);
    send(mk(0, 1), 32'h0000_100B);
    send(mk(1, 0), 32'h0000_100C);
    frz = 1'b1;
    lsu_p      = mk(0, 1);
    lsu_addr_d = 32'h0000_100D;
    tick();
    chk("t3_z_dc5", 64'(da[5]), 64'h1000);
    for (int i = 0; i < 3; i++) begin
      chk("t3_a_dc3", 64'(da[3]), 64'h100A);
      chk("t3_dc4_bub", 64'(dp[4].valid), 64'd0);
      chk("t3_stall", 64'(stall), 64'd1);
      if (i < 2) tick();
    end
    frz = 1'b0;
    tick();
    send(mk(1, 0), 32'h0000_100E);
    drain();

    // Flush with decode packets around a DMA in dc2
    send(mk(1, 0), 32'h0000_2000);
    send(mk(1, 0), 32'h0000_2001);
    send(mk(0, 1), 32'h0000_2002);
    lsu_p    = '0;
    dma_req  = 1'b1;
    dma_addr = 32'hF004_0100;
    dma_sz   = 3'd2;
    dma_wr   = 1'b0;
    tick();
    dma_req = 1'b0;
    send(mk(1, 0), 32'h0000_2003);
    flush = 1'b1;
    lsu_p      = mk(1, 0);
    lsu_addr_d = 32'h0000_2004;
    tick();
    quiet();
    chk("t4_dc1", 64'(dp[1].valid), 64'd0);
    chk("t4_dc2", 64'(dp[2].valid), 64'd0);
    chk("t4_dma3", 64'(dp[3].valid & dp[3].dma), 64'd1);
    chk("t4_dma3a", 64'(da[3]), 64'hF004_0100);
    chk("t4_dc4", 64'(dp[4].valid), 64'd0);
    chk("t4_dc5", 64'(da[5]), 64'h2001);
    drain();

    // Freeze and flush together kill the held dc3
    send(mk(1, 0), 32'h0000_3000);
    send(mk(1, 0), 32'h0000_3001);
    send(mk(1, 0), 32'h0000_3002);
    frz   = 1'b1;
    flush = 1'b1;
    lsu_p = '0;
    tick();
    quiet();
    chk("t5_dc3", 64'(dp[3].valid), 64'd0);
    drain();

    // Reset in mid-stream, released two cycles later
    for (int i = 0; i < 5; i++)
      send(mk(1, 0), 32'h0000_4000 + 32'(i));
    quiet();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_idle", 64'(idle), 64'd1);
    chk("t6_dc3", 64'(dp[3]), 64'd0);
    chk("t6_addr1", 64'(da[1]), 64'd0);
    chk("t6_addr5", 64'(da[5]), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    send(mk(1, 0), 32'h0000_5000);
    quiet();
    chk("t6_dc1", 64'(dp[1].valid), 64'd1);
    chk("t6_dc1a", 64'(da[1]), 64'h5000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
